// File: rtl/line_buffer.sv
// line_buffer: single-entry fetch line buffer holding one cache line, with
// combinational PC lookup returning a hit flag and the addressed word.
module line_buffer #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fill_valid,
  input  logic [ADDR_WIDTH-1:0]      fill_addr,
  input  logic [32*LINE_WORDS-1:0]   fill_data,
  input  logic                       invalidate,
  input  logic [ADDR_WIDTH-1:0]      req_pc,
  output logic                       hit,
  output logic [31:0]                word
);
  localparam int OFF = $clog2(LINE_WORDS) + 2;
  logic                      valid_q, valid_d;
  logic [ADDR_WIDTH-1:OFF]   tag_q, tag_d;
  logic [32*LINE_WORDS-1:0]  data_q, data_d;
  logic                      load;
  // invalidate overrides a coincident fill so a flush never leaves a stale line
  assign load = fill_valid && !invalidate;
  always_comb begin
    valid_d = invalidate ? 1'b0 : (fill_valid ? 1'b1 : valid_q);
    tag_d   = load ? fill_addr[ADDR_WIDTH-1:OFF] : tag_q;
    data_d  = load ? fill_data : data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end
  assign hit  = valid_q && (req_pc[ADDR_WIDTH-1:OFF] == tag_q);
  assign word = hit ? data_q[{req_pc[OFF-1:2], 5'b0} +: 32] : 32'h0;
endmodule

// File: tb/tb_line_buffer.sv
// tb_line_buffer: directed and randomized checks of line_buffer against a
// behavioural model holding the buffered line base address and word array.
module tb_line_buffer;
  localparam int LW = 8;
  localparam int AW = 32;
  logic clk = 1'b0;
  logic rst, fill_valid, invalidate;
  logic [AW-1:0] fill_addr, req_pc;
  logic [32*LW-1:0] fill_data;
  logic hit;
  logic [31:0] word;
  int errors = 0, checks = 0;
  bit m_valid;
  logic [31:0] m_base;
  logic [31:0] m_data [LW];

  line_buffer #(.LINE_WORDS(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .fill_valid(fill_valid), .fill_addr(fill_addr),
    .fill_data(fill_data), .invalidate(invalidate), .req_pc(req_pc),
    .hit(hit), .word(word)
  );

  always #5 clk = ~clk;

  function automatic logic exp_hit(logic [31:0] pc);
    return m_valid && ((pc & ~32'h1F) == m_base);
  endfunction

  function automatic logic [31:0] exp_word(logic [31:0] pc);
    return exp_hit(pc) ? m_data[(pc % 32) / 4] : 32'h0;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_base = '0;
    for (int i = 0; i < LW; i++) m_data[i] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (invalidate) m_valid = 0;
    else if (fill_valid) begin
      m_valid = 1;
      m_base = fill_addr & ~32'h1F;
      for (int i = 0; i < LW; i++) m_data[i] = fill_data[i*32 +: 32];
    end
    #1;
    fill_valid = 0;
    invalidate = 0;
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] base);
    fill_addr = addr;
    for (int i = 0; i < LW; i++) fill_data[i*32 +: 32] = base + i;
    fill_valid = 1;
    tick();
  endtask

  task automatic test_reset();
    req_pc = 32'h0;
    #1;
    checks++;
    if (hit !== 1'b0 || word !== 32'h0) begin
      errors++;
      $display("FAIL reset_hold hit=%b word=%h expected hit=0 word=0", hit, word);
    end
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (hit !== 1'b0 || word !== 32'h0) begin
      errors++;
      $display("FAIL reset_release hit=%b word=%h expected hit=0 word=0", hit, word);
    end
  endtask

  task automatic test_cold_miss();
    req_pc = 32'h10;
    #1;
    checks++;
    if (hit !== 1'b0 || word !== 32'h0) begin
      errors++;
      $display("FAIL cold_miss hit=%b word=%h expected hit=0 word=0", hit, word);
    end
  endtask

  task automatic test_fill_hits();
    load(32'h0, 32'hA5A50000);
    for (int i = 0; i < LW; i++) begin
      req_pc = i * 4;
      #1;
      checks++;
      if (hit !== 1'b1 || word !== 32'hA5A50000 + i) begin
        errors++;
        $display("FAIL fill_hit pc=%h hit=%b word=%h expected hit=1 word=%h",
                 req_pc, hit, word, 32'hA5A50000 + i);
      end
    end
    load(32'h13, 32'hA5A50000);
    req_pc = 32'h1C;
    #1;
    checks++;
    if (hit !== 1'b1 || word !== 32'hA5A50007) begin
      errors++;
      $display("FAIL unaligned_fill hit=%b word=%h expected hit=1 word=a5a50007", hit, word);
    end
  endtask

  task automatic test_different_line();
    req_pc = 32'h100;
    #1;
    checks++;
    if (hit !== 1'b0 || word !== 32'h0) begin
      errors++;
      $display("FAIL other_line hit=%b word=%h expected hit=0 word=0", hit, word);
    end
    req_pc = 32'h1F;
    #1;
    checks++;
    if (hit !== 1'b1 || word !== 32'hA5A50007) begin
      errors++;
      $display("FAIL low_bits_ignored hit=%b word=%h expected hit=1 word=a5a50007", hit, word);
    end
  endtask

  task automatic test_invalidate();
    invalidate = 1;
    tick();
    req_pc = 32'h0;
    #1;
    checks++;
    if (hit !== 1'b0 || word !== 32'h0) begin
      errors++;
      $display("FAIL invalidate hit=%b word=%h expected hit=0 word=0", hit, word);
    end
    load(32'h100, 32'h12340000);
    req_pc = 32'h108;
    #1;
    checks++;
    if (hit !== 1'b1 || word !== 32'h12340002) begin
      errors++;
      $display("FAIL refill hit=%b word=%h expected hit=1 word=12340002", hit, word);
    end
    req_pc = 32'h0;
    #1;
    checks++;
    if (hit !== 1'b0) begin
      errors++;
      $display("FAIL refill_old_line hit=%b expected hit=0", hit);
    end
  endtask

  task automatic test_simultaneous();
    fill_addr = 32'h200;
    for (int i = 0; i < LW; i++) fill_data[i*32 +: 32] = 32'h55550000 + i;
    fill_valid = 1;
    invalidate = 1;
    tick();
    req_pc = 32'h200;
    #1;
    checks++;
    if (hit !== 1'b0 || word !== 32'h0) begin
      errors++;
      $display("FAIL simul_new_line hit=%b word=%h expected hit=0 word=0", hit, word);
    end
    req_pc = 32'h104;
    #1;
    checks++;
    if (hit !== 1'b0) begin
      errors++;
      $display("FAIL simul_old_line hit=%b expected hit=0", hit);
    end
  endtask

  task automatic test_reset_mid();
    load(32'h40, 32'hCAFE0000);
    req_pc = 32'h44;
    #1;
    checks++;
    if (hit !== 1'b1 || word !== 32'hCAFE0001) begin
      errors++;
      $display("FAIL pre_reset_hit hit=%b word=%h expected hit=1 word=cafe0001", hit, word);
    end
    @(negedge clk);
    rst = 1;
    #1;
    model_reset();
    checks++;
    if (hit !== 1'b0 || word !== 32'h0) begin
      errors++;
      $display("FAIL async_reset hit=%b word=%h expected hit=0 word=0", hit, word);
    end
    @(negedge clk);
    rst = 0;
    tick();
    checks++;
    if (hit !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_miss hit=%b expected hit=0", hit);
    end
    load(32'h40, 32'hBEEF0000);
    checks++;
    if (hit !== 1'b1 || word !== 32'hBEEF0001) begin
      errors++;
      $display("FAIL post_reset_fill hit=%b word=%h expected hit=1 word=beef0001", hit, word);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      fill_valid = ($urandom_range(2) == 0);
      invalidate = ($urandom_range(7) == 0);
      fill_addr = $urandom_range(32'h7F);
      for (int i = 0; i < LW; i++) fill_data[i*32 +: 32] = $urandom;
      req_pc = $urandom_range(32'h7F);
      #1;
      checks++;
      if (hit !== exp_hit(req_pc) || word !== exp_word(req_pc)) begin
        errors++;
        $display("FAIL rand_pre_edge pc=%h hit=%b word=%h expected hit=%b word=%h",
                 req_pc, hit, word, exp_hit(req_pc), exp_word(req_pc));
      end
      tick();
      req_pc = $urandom_range(32'h7F);
      #1;
      checks++;
      if (hit !== exp_hit(req_pc) || word !== exp_word(req_pc)) begin
        errors++;
        $display("FAIL rand_post_edge pc=%h hit=%b word=%h expected hit=%b word=%h",
                 req_pc, hit, word, exp_hit(req_pc), exp_word(req_pc));
      end
    end
  endtask

  initial begin
    rst = 1;
    fill_valid = 0;
    invalidate = 0;
    fill_addr = '0;
    fill_data = '0;
    req_pc = '0;
    model_reset();
    #12;
    test_reset();
    test_cold_miss();
    test_fill_hits();
    test_different_line();
    test_invalidate();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
